// File: rtl/ramcard_ptr_ctrl.sv
// Apple II slot-card RAM/ROM controller with NPTR auto-stepping RAM pointers and a ROM bank.
// Define PTR_DEC_EN to make STEP=10 decrement the selected pointer.
`timescale 1ns/1ps
module ramcard_ptr_ctrl #(
    parameter int ADDR_W = 24,
    parameter int NPTR   = 2,
    parameter int BANK_W = 8
) (
    input  logic              C7M,
    input  logic              nRES,
    input  logic              PHI1,
    input  logic [10:0]       A,
    input  logic              nWE,
    input  logic              nDEVSEL,
    input  logic              nIOSEL,
    input  logic              nIOSTRB,
    input  logic [7:0]        Din,
    input  logic [7:0]        RDin,
    output logic [7:0]        Dout,
    output logic              DOE,
    output logic              RDOE,
    output logic [ADDR_W-1:0] RA,
    output logic              RAMCS,
    output logic              nROMCS
);
    localparam logic [ADDR_W-1:0] INC_LO  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] INC_MID = ADDR_W'(1) << 8;
    localparam logic [ADDR_W-1:0] INC_HI  = ADDR_W'(1) << 16;

    logic [2:0]        s;
    logic              phi0_seen;
    logic              phi1_q;
    logic              dben;
    logic              csen;
    logic              regen;
    logic              ioromen;
    logic [ADDR_W-1:0] ptr [4];
    logic [1:0]        step_mode [4];
    logic [1:0]        psel;
    logic [BANK_W-1:0] bank;
    logic              pend;
    logic [1:0]        pend_idx;
    logic [ADDR_W-1:0] pend_delta;

    logic              win_hit;
    logic              port_hit;
    logic              rom_strb;
    logic [23:0]       ptr24;
    logic [23:0]       wr24;
    logic [ADDR_W-1:0] step_delta;
    logic [ADDR_W-1:0] carry_delta;
    logic [BANK_W-1:0] bank_inc;
    logic [7:0]        rd_val;

    // Bus phase: S restarts at 1 on each PHI1 rise, but only once a PHI0 half has been observed.
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            s         <= 3'd0;
            phi0_seen <= 1'b0;
            phi1_q    <= 1'b0;
        end else begin
            phi1_q <= PHI1;
            if (!PHI1)
                phi0_seen <= 1'b1;
            if (PHI1 && !phi1_q && phi0_seen)
                s <= 3'd1;
            else if (s != 3'd0 && s != 3'd7)
                s <= s + 3'd1;
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            dben    <= 1'b0;
            csen    <= 1'b0;
            regen   <= 1'b0;
            ioromen <= 1'b0;
        end else begin
            dben <= s[2];
            csen <= (s == 3'd4 && nWE) || (s >= 3'd5);
            if (s == 3'd4) begin
                if (!nIOSEL)
                    regen <= 1'b1;
                if (!nIOSTRB && A == 11'h7FF)
                    ioromen <= 1'b0;
                else if (!nIOSEL)
                    ioromen <= 1'b1;
            end
        end
    end

    assign win_hit  = !nDEVSEL && regen;
    assign port_hit = win_hit && (A[3:0] == 4'h3);
    assign rom_strb = !nIOSTRB && ioromen;
    assign ptr24    = 24'(ptr[psel]);
    assign bank_inc = bank + 1'b1;

    always_comb begin
        wr24 = ptr24;
        case (A[1:0])
            2'd0:    wr24[7:0]   = Din;
            2'd1:    wr24[15:8]  = Din;
            default: wr24[23:16] = Din;
        endcase
    end

    // A byte write that drops bit 7 from 1 to 0 counts as a wrap and carries into the next byte.
    always_comb begin
        carry_delta = '0;
        if (A[3:0] == 4'h0 && ptr24[7] && !Din[7])
            carry_delta = INC_MID;
        else if (A[3:0] == 4'h1 && ptr24[15] && !Din[7])
            carry_delta = INC_HI;
    end

    always_comb begin
        step_delta = '0;
        case (step_mode[psel])
            2'b00:   step_delta = INC_LO;
`ifdef PTR_DEC_EN
            2'b10:   step_delta = '1;
`endif
            default: step_delta = '0;
        endcase
    end

    // Steps are queued at S=6 and applied at S=1 of the next bus cycle, so a
    // pointer write in that later cycle (S=6) always lands after the step.
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            for (int i = 0; i < 4; i++) begin
                ptr[i]       <= '0;
                step_mode[i] <= 2'b00;
            end
            psel       <= 2'd0;
            bank       <= '0;
            pend       <= 1'b0;
            pend_idx   <= 2'd0;
            pend_delta <= '0;
        end else begin
            if (s == 3'd1 && pend) begin
                ptr[pend_idx] <= ptr[pend_idx] + pend_delta;
                pend          <= 1'b0;
            end
            if (s == 3'd6 && win_hit) begin
                if (port_hit && step_delta != '0) begin
                    pend       <= 1'b1;
                    pend_idx   <= psel;
                    pend_delta <= step_delta;
                end
                if (!nWE) begin
                    case (A[3:0])
                        4'h0, 4'h1, 4'h2: begin
                            ptr[psel] <= ADDR_W'(wr24);
                            if (carry_delta != '0) begin
                                pend       <= 1'b1;
                                pend_idx   <= psel;
                                pend_delta <= carry_delta;
                            end
                        end
                        4'h4: begin
                            if (int'(Din[1:0]) < NPTR) begin
                                psel                 <= Din[1:0];
                                step_mode[Din[1:0]]  <= Din[5:4];
                            end
                        end
                        4'hF: bank <= BANK_W'(Din);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        if (!nIOSTRB)
            RA = ADDR_W'({bank_inc, A});
        else if (!nIOSEL)
            RA = ADDR_W'(A[7:0]);
        else
            RA = ptr[psel];
    end

    always_comb begin
        rd_val = RDin;
        if (win_hit) begin
            case (A[3:0])
                4'h0:    rd_val = ptr24[7:0];
                4'h1:    rd_val = ptr24[15:8];
                4'h2:    rd_val = ptr24[23:16];
                4'h3:    rd_val = RDin;
                4'h4:    rd_val = {2'b00, step_mode[psel], 2'b00, psel};
                4'hF:    rd_val = 8'(bank);
                default: rd_val = 8'h00;
            endcase
        end
    end

    assign RAMCS  = port_hit && csen;
    assign nROMCS = !(csen && (!nIOSEL || rom_strb));
    assign DOE    = dben && nWE && (win_hit || !nIOSEL || rom_strb);
    assign RDOE   = dben && !nWE && RAMCS;
    assign Dout   = DOE ? rd_val : 8'h00;

endmodule

// File: tb/tb_ramcard_ptr_ctrl.sv
// Scoreboard bench for ramcard_ptr_ctrl: drivers queue expected outputs tagged with
// the clock at which they must appear; a monitor compares them on falling C7M edges.
`timescale 1ns/1ps
module tb_ramcard_ptr_ctrl;
    logic        C7M = 1'b0;
    logic        nRES;
    logic        PHI1;
    logic [10:0] A;
    logic        nWE;
    logic        nDEVSEL;
    logic        nIOSEL;
    logic        nIOSTRB;
    logic [7:0]  Din;
    logic [7:0]  RDin;
    logic [7:0]  Dout;
    logic        DOE;
    logic        RDOE;
    logic [23:0] RA;
    logic        RAMCS;
    logic        nROMCS;

    ramcard_ptr_ctrl dut (
        .C7M(C7M), .nRES(nRES), .PHI1(PHI1), .A(A), .nWE(nWE),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
        .Din(Din), .RDin(RDin), .Dout(Dout), .DOE(DOE), .RDOE(RDOE),
        .RA(RA), .RAMCS(RAMCS), .nROMCS(nROMCS)
    );

    always #5 C7M = ~C7M;

    typedef enum int {SIG_RA, SIG_RAMCS, SIG_NROMCS, SIG_DOE, SIG_RDOE, SIG_DOUT} sig_e;
    typedef struct {
        int unsigned cyc;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    localparam int K_IDLE = 0, K_DEV = 1, K_IOSEL = 2, K_IOSTRB = 3;

    exp_t        exp_q[$];
    exp_t        keep_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge C7M) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input sig_e sg);
        case (sg)
            SIG_RA:     return 32'(RA);
            SIG_RAMCS:  return 32'(RAMCS);
            SIG_NROMCS: return 32'(nROMCS);
            SIG_DOE:    return 32'(DOE);
            SIG_RDOE:   return 32'(RDOE);
            default:    return 32'(Dout);
        endcase
    endfunction

    // Monitor: every expectation due at this clock is compared and retired.
    always @(negedge C7M) begin
        keep_q = {};
        foreach (exp_q[i]) begin
            if (exp_q[i].cyc == cyc) begin
                checks++;
                if (actual(exp_q[i].sig) !== exp_q[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", exp_q[i].name, cyc,
                             actual(exp_q[i].sig), exp_q[i].val);
                end
            end else if (exp_q[i].cyc < cyc) begin
                failures++;
                $display("FAIL %s missed cyc=%0d now=%0d", exp_q[i].name, exp_q[i].cyc, cyc);
            end else begin
                keep_q.push_back(exp_q[i]);
            end
        end
        exp_q = keep_q;
    end

    // k is relative to the next rising edge (the edge where a new bus cycle's S becomes 1).
    task automatic expect_k(input int k, input sig_e sg, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc + 1 + k;
        e.sig  = sg;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // One 8-clock bus cycle: PHI1 high for 4 edges, low for 4. rst_k >= 0 drops nRES mid-cycle.
    task automatic bus_cycle(input int kind, input logic [10:0] addr, input logic rd,
                             input logic [7:0] data, input int rst_k);
        A       = addr;
        nWE     = rd;
        Din     = data;
        nDEVSEL = (kind != K_DEV);
        nIOSEL  = (kind != K_IOSEL);
        nIOSTRB = (kind != K_IOSTRB);
        PHI1    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge C7M);
            if (k == 3) PHI1 = 1'b0;
            if (k == rst_k) nRES = 1'b0;
        end
        nRES = 1'b1;
    endtask

    task automatic reg_wr(input logic [3:0] off, input logic [7:0] data);
        bus_cycle(K_DEV, {7'h00, off}, 1'b0, data, -1);
    endtask

    task automatic reg_rd(input logic [3:0] off);
        bus_cycle(K_DEV, {7'h00, off}, 1'b1, 8'h00, -1);
    endtask

    initial begin
        nRES = 1'b0; PHI1 = 1'b0; A = '0; nWE = 1'b1; Din = '0; RDin = 8'hA7;
        nDEVSEL = 1'b1; nIOSEL = 1'b1; nIOSTRB = 1'b1;
        repeat (2) @(negedge C7M);
        expect_k(0, SIG_RA, 0, "rst_ra");
        expect_k(0, SIG_RAMCS, 0, "rst_ramcs");
        expect_k(0, SIG_NROMCS, 1, "rst_nromcs");
        expect_k(0, SIG_DOE, 0, "rst_doe");
        expect_k(0, SIG_RDOE, 0, "rst_rdoe");
        expect_k(0, SIG_DOUT, 0, "rst_dout");
        repeat (3) @(negedge C7M);
        nRES = 1'b1;
        repeat (3) @(negedge C7M);

        // IOSEL ROM read enables the register window
        expect_k(2, SIG_NROMCS, 1, "iosel_nromcs_s3");
        expect_k(4, SIG_RA, 32'h0000C5, "iosel_ra");
        expect_k(4, SIG_NROMCS, 0, "iosel_nromcs_s5");
        expect_k(6, SIG_NROMCS, 0, "iosel_nromcs_s7");
        expect_k(2, SIG_DOE, 0, "iosel_doe_s3");
        expect_k(5, SIG_DOE, 1, "iosel_doe_s6");
        expect_k(5, SIG_DOUT, 8'hA7, "iosel_dout");
        bus_cycle(K_IOSEL, 11'h0C5, 1'b1, 8'h00, -1);

        // Data-port read with PTR0=0, then it steps to 1
        expect_k(2, SIG_RAMCS, 0, "dp_rd_ramcs_s3");
        expect_k(4, SIG_RA, 0, "dp_rd_ra_s5");
        expect_k(4, SIG_RAMCS, 1, "dp_rd_ramcs_s5");
        expect_k(6, SIG_RAMCS, 1, "dp_rd_ramcs_s7");
        expect_k(5, SIG_DOE, 1, "dp_rd_doe");
        expect_k(5, SIG_DOUT, 8'hA7, "dp_rd_dout");
        expect_k(5, SIG_RDOE, 0, "dp_rd_rdoe");
        expect_k(9, SIG_RA, 1, "dp_rd_step");
        reg_rd(4'h3);

        // Lo writes 80 then 05: carry into mid
        expect_k(6, SIG_RA, 32'h000080, "wr_lo80_ra");
        expect_k(5, SIG_RAMCS, 0, "wr_lo_ramcs");
        expect_k(5, SIG_RDOE, 0, "wr_lo_rdoe");
        reg_wr(4'h0, 8'h80);
        expect_k(6, SIG_RA, 32'h000005, "wr_lo05_ra");
        expect_k(9, SIG_RA, 32'h000105, "wr_lo_carry");
        reg_wr(4'h0, 8'h05);
        expect_k(5, SIG_DOUT, 8'h01, "rd_mid");
        expect_k(5, SIG_DOE, 1, "rd_mid_doe");
        reg_rd(4'h1);

        // Data-port write
        expect_k(4, SIG_RAMCS, 0, "dp_wr_ramcs_s5");
        expect_k(5, SIG_RAMCS, 1, "dp_wr_ramcs_s6");
        expect_k(5, SIG_RDOE, 1, "dp_wr_rdoe");
        expect_k(5, SIG_DOE, 0, "dp_wr_doe");
        expect_k(5, SIG_RA, 32'h000105, "dp_wr_ra");
        expect_k(9, SIG_RA, 32'h000106, "dp_wr_step");
        bus_cycle(K_DEV, 11'h003, 1'b0, 8'h3C, -1);

        // Back-to-back data-port reads
        expect_k(4, SIG_RA, 32'h000106, "b2b_ra0");
        expect_k(12, SIG_RA, 32'h000107, "b2b_ra1");
        expect_k(17, SIG_RA, 32'h000108, "b2b_ra2");
        reg_rd(4'h3);
        reg_rd(4'h3);

        // Wrap at FFFFFF
        expect_k(6, SIG_RA, 32'hFF0108, "wr_hi_ra");
        reg_wr(4'h2, 8'hFF);
        expect_k(6, SIG_RA, 32'hFFFF08, "wr_mid_ra");
        reg_wr(4'h1, 8'hFF);
        expect_k(6, SIG_RA, 32'hFFFFFF, "wr_loff_ra");
        reg_wr(4'h0, 8'hFF);
        expect_k(4, SIG_RA, 32'hFFFFFF, "wrap_ra_s5");
        expect_k(9, SIG_RA, 32'h000000, "wrap_step");
        reg_rd(4'h3);

        // Mid-byte carry into hi
        expect_k(6, SIG_RA, 32'h008000, "wr_mid80_ra");
        reg_wr(4'h1, 8'h80);
        expect_k(6, SIG_RA, 32'h000500, "wr_mid05_ra");
        expect_k(9, SIG_RA, 32'h010500, "mid_carry");
        reg_wr(4'h1, 8'h05);

        // PSEL=1, STEP=10
        expect_k(6, SIG_RA, 32'h000000, "psel1_ra");
        reg_wr(4'h4, 8'h21);
        expect_k(5, SIG_DOUT, 8'h21, "ctrl_rd");
        reg_rd(4'h4);
        expect_k(4, SIG_RA, 32'h000000, "dec_ra_s5");
`ifdef PTR_DEC_EN
        expect_k(9, SIG_RA, 32'hFFFFFF, "dec_step");
`else
        expect_k(9, SIG_RA, 32'h000000, "dec_hold");
`endif
        reg_rd(4'h3);
        expect_k(5, SIG_DOUT, 8'h00, "unmapped_rd");
        expect_k(5, SIG_DOE, 1, "unmapped_doe");
        reg_rd(4'h5);

        // ROM bank and IOSTRB window
        reg_wr(4'hF, 8'h03);
        expect_k(5, SIG_DOUT, 8'h03, "bank_rd");
        reg_rd(4'hF);
        expect_k(4, SIG_RA, 32'h002123, "strb_ra");
        expect_k(4, SIG_NROMCS, 0, "strb_nromcs_s5");
        expect_k(6, SIG_NROMCS, 0, "strb_nromcs_s7");
        expect_k(5, SIG_DOE, 1, "strb_doe");
        expect_k(5, SIG_DOUT, 8'hA7, "strb_dout");
        bus_cycle(K_IOSTRB, 11'h123, 1'b1, 8'h00, -1);
        expect_k(5, SIG_DOE, 0, "strb7ff_doe");
        bus_cycle(K_IOSTRB, 11'h7FF, 1'b1, 8'h00, -1);
        expect_k(4, SIG_RA, 32'h002123, "strb_off_ra");
        expect_k(5, SIG_DOE, 0, "strb_off_doe");
        expect_k(5, SIG_NROMCS, 1, "strb_off_nromcs");
        bus_cycle(K_IOSTRB, 11'h123, 1'b1, 8'h00, -1);

        // Reset at S=6 of a data-port write
        reg_wr(4'h4, 8'h00);
        expect_k(4, SIG_RA, 32'h010500, "mrst_ra_before");
        expect_k(6, SIG_RA, 0, "mrst_ra");
        expect_k(6, SIG_RAMCS, 0, "mrst_ramcs");
        expect_k(6, SIG_NROMCS, 1, "mrst_nromcs");
        expect_k(6, SIG_DOE, 0, "mrst_doe");
        expect_k(6, SIG_RDOE, 0, "mrst_rdoe");
        expect_k(6, SIG_DOUT, 0, "mrst_dout");
        bus_cycle(K_DEV, 11'h003, 1'b0, 8'h11, 5);
        expect_k(4, SIG_NROMCS, 1, "idle_nromcs");
        expect_k(5, SIG_DOE, 0, "idle_doe");
        bus_cycle(K_IOSEL, 11'h0C5, 1'b1, 8'h00, -1);
        expect_k(4, SIG_NROMCS, 0, "resync_nromcs");
        bus_cycle(K_IOSEL, 11'h0C5, 1'b1, 8'h00, -1);
        expect_k(4, SIG_RA, 0, "post_rst_ra");
        expect_k(4, SIG_RAMCS, 1, "post_rst_ramcs");
        expect_k(9, SIG_RA, 1, "post_rst_step");
        reg_rd(4'h3);
        bus_cycle(K_IDLE, 11'h000, 1'b1, 8'h00, -1);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge C7M);
        if (exp_q.size() > 0) begin
            failures += exp_q.size();
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
